// File: rtl/weight_buffer_cfg_if.sv
// Bus bundle between the weight buffer and its controller / memory / PE side.
// The master modport is the controller side, the slave modport is the buffer.
interface weight_buffer_cfg_if #(
  parameter int MEM_W      = 64,
  parameter int ELEM_W     = 8,
  parameter int FILTER_W   = 11,
  parameter int DEPTH      = 44,
  parameter int LANES      = 6,
  parameter int CHUNK_W    = 32,
  parameter int MAX_LAYERS = 4
);
  localparam int ROW_W  = FILTER_W * ELEM_W;
  localparam int CHUNKS = (ROW_W + CHUNK_W - 1) / CHUNK_W;
  localparam int RW_W   = $clog2(DEPTH + 1);
  localparam int LN_W   = $clog2(LANES + 1);
  localparam int LY_W   = $clog2(MAX_LAYERS + 1);
  localparam int OL_W   = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
  localparam int CK_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  logic                     cfg_valid;
  logic [RW_W-1:0]          cfg_rows;
  logic [LN_W-1:0]          cfg_lanes;
  logic [LY_W-1:0]          cfg_layers;
  logic                     mem_req;
  logic                     mem_valid;
  logic [MEM_W-1:0]         mem_data;
  logic                     free;
  logic                     ready;
  logic                     out_start;
  logic [LANES-1:0]         out_valid;
  logic [LANES*CHUNK_W-1:0] out_data;
  logic [OL_W-1:0]          out_layer;
  logic [CK_W-1:0]          out_chunk;
  logic                     out_done;

  modport master (
    output cfg_valid, cfg_rows, cfg_lanes, cfg_layers, mem_valid, mem_data, free, out_start,
    input  mem_req, ready, out_valid, out_data, out_layer, out_chunk, out_done
  );

  modport slave (
    input  cfg_valid, cfg_rows, cfg_lanes, cfg_layers, mem_valid, mem_data, free, out_start,
    output mem_req, ready, out_valid, out_data, out_layer, out_chunk, out_done
  );
endinterface

// File: rtl/weight_buffer_cfg.sv
// Runtime-configured filter weight buffer: loads cfg_rows rows from memory in
// MEM_W-bit beats, then streams them to cfg_lanes PE lanes, CHUNK_W bits per
// lane per cycle, for cfg_layers layers. A loaded filter can be replayed.
// Optional macro WEIGHT_BUFFER_CFG_OUT_REG_EN adds one output register stage
// on out_valid/out_data/out_layer/out_chunk/out_done (latency 2 instead of 1).
module weight_buffer_cfg #(
  parameter int MEM_W      = 64,
  parameter int ELEM_W     = 8,
  parameter int FILTER_W   = 11,
  parameter int DEPTH      = 44,
  parameter int LANES      = 6,
  parameter int CHUNK_W    = 32,
  parameter int MAX_LAYERS = 4
) (
  input logic               clk,
  input logic               rst_n,
  weight_buffer_cfg_if.slave bus
);
  localparam int ROW_W  = FILTER_W * ELEM_W;
  localparam int BEATS  = (ROW_W + MEM_W - 1) / MEM_W;
  localparam int CHUNKS = (ROW_W + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_W  = CHUNKS * CHUNK_W;
  localparam int RW_W   = $clog2(DEPTH + 1);
  localparam int LN_W   = $clog2(LANES + 1);
  localparam int LY_W   = $clog2(MAX_LAYERS + 1);
  localparam int OL_W   = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
  localparam int CK_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int BT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RI_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OD_W   = LANES * CHUNK_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FULL   = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t            state_r;
  logic [RW_W-1:0]   cfg_rows_r;
  logic [LN_W-1:0]   cfg_lanes_r;
  logic [LY_W-1:0]   cfg_layers_r;
  logic [RW_W-1:0]   row_cnt_r;
  logic [BT_W-1:0]   beat_cnt_r;
  logic [LY_W-1:0]   layer_cnt_r;
  logic [CK_W-1:0]   chunk_cnt_r;
  logic              mem_req_r;
  logic              ready_r;
  logic [LANES-1:0]  out_valid_r;
  logic [OD_W-1:0]   out_data_r;
  logic [OL_W-1:0]   out_layer_r;
  logic [CK_W-1:0]   out_chunk_r;
  logic              out_done_r;

  logic [ROW_W-1:0]  row_mem_r [DEPTH];

  logic              cfg_ok_s;
  logic              accept_s;
  logic              last_beat_s;
  logic              last_row_s;
  logic [LY_W-1:0]   sel_layer_s;
  logic [CK_W-1:0]   sel_chunk_s;
  logic [LY_W-1:0]   nxt_layer_s;
  logic [CK_W-1:0]   nxt_chunk_s;
  logic [LANES-1:0]  lane_valid_s;
  logic [OD_W-1:0]   lane_data_s;

  // Overlay one memory beat onto a row at beat position beat_idx; bits past ROW_W drop off.
  function automatic logic [ROW_W-1:0] merge_beat(input logic [ROW_W-1:0] old_row,
                                                  input logic [MEM_W-1:0] beat_data,
                                                  input int beat_idx);
    logic [ROW_W-1:0] mask_v;
    logic [ROW_W-1:0] data_v;
    mask_v = ROW_W'({MEM_W{1'b1}}) << (beat_idx * MEM_W);
    data_v = ROW_W'(beat_data) << (beat_idx * MEM_W);
    return (old_row & ~mask_v) | (data_v & mask_v);
  endfunction

  // Extract chunk idx of a row, zero-padded above ROW_W.
  function automatic logic [CHUNK_W-1:0] get_chunk(input logic [ROW_W-1:0] row_v, input int idx);
    logic [PAD_W-1:0] pad_v;
    pad_v = PAD_W'(row_v);
    return CHUNK_W'(pad_v >> (idx * CHUNK_W));
  endfunction

  assign cfg_ok_s    = (bus.cfg_rows != {RW_W{1'b0}}) && (bus.cfg_rows <= RW_W'(DEPTH)) &&
                       (bus.cfg_lanes != {LN_W{1'b0}}) && (bus.cfg_lanes <= LN_W'(LANES)) &&
                       (bus.cfg_layers != {LY_W{1'b0}}) && (bus.cfg_layers <= LY_W'(MAX_LAYERS));
  assign accept_s    = (state_r == ST_LOAD) && mem_req_r && bus.mem_valid && !bus.free;
  assign last_beat_s = (beat_cnt_r == BT_W'(BEATS - 1));
  assign last_row_s  = (row_cnt_r == (cfg_rows_r - RW_W'(1)));

  // Chunk to issue this cycle (first chunk when starting a pass) and its lane payload.
  always_comb begin
    sel_layer_s  = {LY_W{1'b0}};
    sel_chunk_s  = {CK_W{1'b0}};
    nxt_layer_s  = {LY_W{1'b0}};
    nxt_chunk_s  = {CK_W{1'b0}};
    lane_valid_s = {LANES{1'b0}};
    lane_data_s  = {OD_W{1'b0}};
    if (state_r == ST_STREAM) begin
      sel_layer_s = layer_cnt_r;
      sel_chunk_s = chunk_cnt_r;
    end else begin
      sel_layer_s = {LY_W{1'b0}};
      sel_chunk_s = {CK_W{1'b0}};
    end
    if (sel_chunk_s == CK_W'(CHUNKS - 1)) begin
      nxt_chunk_s = {CK_W{1'b0}};
      nxt_layer_s = sel_layer_s + LY_W'(1);
    end else begin
      nxt_chunk_s = sel_chunk_s + CK_W'(1);
      nxt_layer_s = sel_layer_s;
    end
    for (int i = 0; i < LANES; i++) begin
      int row_idx;
      row_idx = int'(sel_layer_s) * int'(cfg_lanes_r) + i;
      if ((i < int'(cfg_lanes_r)) && (row_idx < int'(cfg_rows_r))) begin
        lane_valid_s[i] = 1'b1;
        lane_data_s[i*CHUNK_W +: CHUNK_W] =
          get_chunk(row_mem_r[RI_W'(row_idx)], CHUNKS - 1 - int'(sel_chunk_s));
      end else begin
        lane_valid_s[i] = 1'b0;
        lane_data_s[i*CHUNK_W +: CHUNK_W] = {CHUNK_W{1'b0}};
      end
    end
  end

  // Row file write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      row_mem_r[RI_W'(row_cnt_r)] <= merge_beat(row_mem_r[RI_W'(row_cnt_r)], bus.mem_data,
                                                int'(beat_cnt_r));
    end
  end

  // Main control FSM with registered handshake and stream outputs; free overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.free) begin
      state_r      <= ST_IDLE;
      cfg_rows_r   <= {RW_W{1'b0}};
      cfg_lanes_r  <= {LN_W{1'b0}};
      cfg_layers_r <= {LY_W{1'b0}};
      row_cnt_r    <= {RW_W{1'b0}};
      beat_cnt_r   <= {BT_W{1'b0}};
      layer_cnt_r  <= {LY_W{1'b0}};
      chunk_cnt_r  <= {CK_W{1'b0}};
      mem_req_r    <= 1'b0;
      ready_r      <= 1'b0;
      out_valid_r  <= {LANES{1'b0}};
      out_data_r   <= {OD_W{1'b0}};
      out_layer_r  <= {OL_W{1'b0}};
      out_chunk_r  <= {CK_W{1'b0}};
      out_done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.cfg_valid && cfg_ok_s) begin
            cfg_rows_r   <= bus.cfg_rows;
            cfg_lanes_r  <= bus.cfg_lanes;
            cfg_layers_r <= bus.cfg_layers;
            row_cnt_r    <= {RW_W{1'b0}};
            beat_cnt_r   <= {BT_W{1'b0}};
            mem_req_r    <= 1'b1;
            state_r      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            if (last_beat_s) begin
              beat_cnt_r <= {BT_W{1'b0}};
              if (last_row_s) begin
                mem_req_r <= 1'b0;
                ready_r   <= 1'b1;
                state_r   <= ST_FULL;
              end else begin
                row_cnt_r <= row_cnt_r + RW_W'(1);
              end
            end else begin
              beat_cnt_r <= beat_cnt_r + BT_W'(1);
            end
          end
        end
        ST_FULL, ST_DONE, ST_STREAM: begin
          if ((state_r == ST_STREAM) && (layer_cnt_r == cfg_layers_r)) begin
            out_valid_r <= {LANES{1'b0}};
            out_data_r  <= {OD_W{1'b0}};
            out_layer_r <= {OL_W{1'b0}};
            out_chunk_r <= {CK_W{1'b0}};
            out_done_r  <= 1'b1;
            state_r     <= ST_DONE;
          end else if ((state_r == ST_STREAM) || bus.out_start) begin
            out_valid_r <= lane_valid_s;
            out_data_r  <= lane_data_s;
            out_layer_r <= OL_W'(sel_layer_s);
            out_chunk_r <= sel_chunk_s;
            out_done_r  <= 1'b0;
            layer_cnt_r <= nxt_layer_s;
            chunk_cnt_r <= nxt_chunk_s;
            state_r     <= ST_STREAM;
          end else begin
            out_done_r  <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
          ready_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req = mem_req_r;
  assign bus.ready   = ready_r;

`ifdef WEIGHT_BUFFER_CFG_OUT_REG_EN
  logic [LANES-1:0] out_valid_q_r;
  logic [OD_W-1:0]  out_data_q_r;
  logic [OL_W-1:0]  out_layer_q_r;
  logic [CK_W-1:0]  out_chunk_q_r;
  logic             out_done_q_r;

  // Extra output stage; the done pulse travels with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.free) begin
      out_valid_q_r <= {LANES{1'b0}};
      out_data_q_r  <= {OD_W{1'b0}};
      out_layer_q_r <= {OL_W{1'b0}};
      out_chunk_q_r <= {CK_W{1'b0}};
      out_done_q_r  <= 1'b0;
    end else begin
      out_valid_q_r <= out_valid_r;
      out_data_q_r  <= out_data_r;
      out_layer_q_r <= out_layer_r;
      out_chunk_q_r <= out_chunk_r;
      out_done_q_r  <= out_done_r;
    end
  end

  assign bus.out_valid = out_valid_q_r;
  assign bus.out_data  = out_data_q_r;
  assign bus.out_layer = out_layer_q_r;
  assign bus.out_chunk = out_chunk_q_r;
  assign bus.out_done  = out_done_q_r;
`else
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_layer = out_layer_r;
  assign bus.out_chunk = out_chunk_r;
  assign bus.out_done  = out_done_r;
`endif
endmodule

// File: tb/tb_weight_buffer_cfg.sv
// Scoreboard bench for weight_buffer_cfg: the stimulus side records every
// accepted memory beat into a reference row file and pushes the expected
// output cycles of each pass into a queue; a monitor pops and compares.
module tb_weight_buffer_cfg;
  localparam int MEM_W      = 64;
  localparam int ELEM_W     = 8;
  localparam int FILTER_W   = 11;
  localparam int DEPTH      = 44;
  localparam int LANES      = 6;
  localparam int CHUNK_W    = 32;
  localparam int MAX_LAYERS = 4;
  localparam int ROW_W      = FILTER_W * ELEM_W;
  localparam int BEATS      = (ROW_W + MEM_W - 1) / MEM_W;
  localparam int CHUNKS     = (ROW_W + CHUNK_W - 1) / CHUNK_W;
`ifdef WEIGHT_BUFFER_CFG_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  weight_buffer_cfg_if #(.MEM_W(MEM_W), .ELEM_W(ELEM_W), .FILTER_W(FILTER_W), .DEPTH(DEPTH),
                         .LANES(LANES), .CHUNK_W(CHUNK_W), .MAX_LAYERS(MAX_LAYERS)) bus ();

  weight_buffer_cfg #(.MEM_W(MEM_W), .ELEM_W(ELEM_W), .FILTER_W(FILTER_W), .DEPTH(DEPTH),
                      .LANES(LANES), .CHUNK_W(CHUNK_W), .MAX_LAYERS(MAX_LAYERS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [LANES-1:0]         valid;
    logic [LANES*CHUNK_W-1:0] data;
    int                       layer;
    int                       chunk;
    bit                       done;
  } exp_t;

  exp_t exp_q[$];
  logic [BEATS*MEM_W-1:0] beat_rows [DEPTH];
  int n_checks = 0;
  int n_pass   = 0;
  int cur_rows, cur_lanes, cur_layers;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CHUNK_W-1:0] ref_chunk(input int r, input int c);
    logic [CHUNKS*CHUNK_W-1:0] pad;
    pad = '0;
    pad[ROW_W-1:0] = beat_rows[r][ROW_W-1:0];
    return pad[(CHUNKS-1-c)*CHUNK_W +: CHUNK_W];
  endfunction

  // Monitor: every cycle the DUT presents valid data or a done pulse, compare with the queue head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && (bus.out_valid != '0 || bus.out_done)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {bus.out_done, bus.out_valid}, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_valid", bus.out_valid, e.valid);
          chk("out_data", bus.out_data, e.data);
          chk("out_done", bus.out_done, e.done);
          if (!e.done) begin
            chk("out_layer", bus.out_layer, e.layer);
            chk("out_chunk", bus.out_chunk, e.chunk);
          end
        end
      end
    end
  end

  task automatic do_cfg(input int r, input int l, input int y, input bit record);
    bus.cfg_rows   = r[5:0];
    bus.cfg_lanes  = l[2:0];
    bus.cfg_layers = y[2:0];
    bus.cfg_valid  = 1'b1;
    tick();
    bus.cfg_valid  = 1'b0;
    if (record) begin
      cur_rows = r; cur_lanes = l; cur_layers = y;
      chk("load_starts", bus.mem_req, 1);
    end
  endtask

  // mode 0: mem_valid held 1, mode 1: toggles 1,0,1,0, mode 2: random.
  task automatic do_load(input int mode);
    int acc = 0;
    int reqcyc = 0;
    int cyc = 0;
    int total;
    logic v;
    logic [MEM_W-1:0] d;
    total = cur_rows * BEATS;
    while (acc < total && cyc < 4000) begin
      if (bus.mem_req) reqcyc++;
      case (mode)
        1: v = (cyc % 2 == 0);
        2: v = 1'($urandom_range(0, 1));
        default: v = 1'b1;
      endcase
      d = {$urandom, $urandom};
      bus.mem_valid = v;
      bus.mem_data  = d;
      if (bus.mem_req && v) begin
        beat_rows[acc / BEATS][(acc % BEATS)*MEM_W +: MEM_W] = d;
        acc++;
      end
      cyc++;
      tick();
    end
    bus.mem_valid = 1'b0;
    chk("load_beats", acc, total);
    chk("ready_after_load", bus.ready, 1);
    chk("req_drop_after_load", bus.mem_req, 0);
    if (mode == 0) chk("req_cycles_held", reqcyc, total);
    else if (mode == 1) chk("req_cycles_toggle", reqcyc, 2*total - 1);
  endtask

  task automatic push_pass();
    exp_t e;
    for (int l = 0; l < cur_layers; l++) begin
      for (int c = 0; c < CHUNKS; c++) begin
        e.valid = '0; e.data = '0; e.layer = l; e.chunk = c; e.done = 1'b0;
        for (int i = 0; i < LANES; i++) begin
          int r;
          r = l * cur_lanes + i;
          if (i < cur_lanes && r < cur_rows) begin
            e.valid[i] = 1'b1;
            e.data[i*CHUNK_W +: CHUNK_W] = ref_chunk(r, c);
          end
        end
        if (e.valid != '0) exp_q.push_back(e);
      end
    end
    e.valid = '0; e.data = '0; e.layer = 0; e.chunk = 0; e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic do_pass(input bit extra_start, input bit row0_chk);
    int n;
    int first = -1;
    bit req_seen = 1'b0;
    bit got_done = 1'b0;
    logic [CHUNK_W-1:0] r0;
    r0 = {8'h00, beat_rows[0][87:64]};
    push_pass();
    bus.out_start = 1'b1;
    tick();
    bus.out_start = 1'b0;
    n = 1;
    while (n < 200) begin
      if (first < 0 && bus.out_valid != '0) first = n;
      if (row0_chk && n == LAT) chk("row0_first_chunk", bus.out_data[CHUNK_W-1:0], r0);
      if (bus.mem_req) req_seen = 1'b1;
      if (bus.out_done) begin
        got_done = 1'b1;
        break;
      end
      bus.out_start = extra_start && (n == 3);
      tick();
      n++;
    end
    bus.out_start = 1'b0;
    chk("pass_done_seen", got_done, 1);
    chk("pass_length", n, cur_layers * CHUNKS + LAT);
    chk("first_chunk_latency", first, LAT);
    chk("no_req_in_pass", req_seen, 0);
    tick();
    chk("done_one_cycle", bus.out_done, 0);
    chk("valid_after_done", bus.out_valid, 0);
    chk("ready_in_done", bus.ready, 1);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  task automatic do_free();
    bus.free = 1'b1;
    tick();
    bus.free = 1'b0;
    chk("free_outputs", {bus.mem_req, bus.ready, bus.out_done, bus.out_valid, bus.out_layer,
                         bus.out_chunk}, 0);
    chk("free_data", bus.out_data, 0);
  endtask

  initial begin
    int bad [6][3];
    bus.cfg_valid = 1'b0; bus.cfg_rows = '0; bus.cfg_lanes = '0; bus.cfg_layers = '0;
    bus.mem_valid = 1'b0; bus.mem_data = '0; bus.free = 1'b0; bus.out_start = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_ready", bus.ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_done", bus.out_done, 0);
    chk("rst_out_layer", bus.out_layer, 0);
    chk("rst_out_chunk", bus.out_chunk, 0);
    rst_n = 1'b1;
    tick();

    // Full default configuration; extra beats offered after the load must be ignored.
    do_cfg(24, 6, 4, 1'b1);
    do_load(0);
    bus.mem_valid = 1'b1;
    repeat (3) begin
      bus.mem_data = {$urandom, $urandom};
      tick();
      chk("no_req_when_full", bus.mem_req, 0);
    end
    bus.mem_valid = 1'b0;
    do_pass(1'b0, 1'b1);

    // Out-of-range configurations leave the block idle.
    do_free();
    bad = '{'{0, 6, 4}, '{45, 6, 4}, '{24, 0, 4}, '{24, 7, 4}, '{24, 6, 0}, '{24, 6, 5}};
    for (int k = 0; k < 6; k++) begin
      do_cfg(bad[k][0], bad[k][1], bad[k][2], 1'b0);
      tick();
      chk("illegal_cfg_idle", {bus.mem_req, bus.ready}, 0);
    end

    // Five lanes; a cfg strobe while FULL must not disturb the loaded configuration.
    do_cfg(20, 5, 4, 1'b1);
    do_load(0);
    do_cfg(10, 3, 2, 1'b0);
    chk("cfg_ignored_in_full", {bus.mem_req, bus.ready}, 2'b01);
    do_pass(1'b0, 1'b0);

    // Short filter with absent rows, then replay (with a stray out_start mid-stream).
    do_free();
    do_cfg(10, 3, 4, 1'b1);
    do_load(0);
    do_pass(1'b0, 1'b0);
    do_pass(1'b1, 1'b0);

    // Toggling mem_valid, then free in the middle of a pass.
    do_free();
    do_cfg(24, 6, 4, 1'b1);
    do_load(1);
    push_pass();
    bus.out_start = 1'b1;
    tick();
    bus.out_start = 1'b0;
    repeat (3) tick();
    do_free();
    exp_q.delete();
    tick();
    chk("idle_after_free", {bus.mem_req, bus.ready, bus.out_valid}, 0);

    // Asynchronous reset in the middle of a load.
    do_cfg(12, 4, 3, 1'b1);
    bus.mem_valid = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req", bus.mem_req, 0);
    chk("async_rst_ready", bus.ready, 0);
    bus.mem_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();

    // Randomised configurations and memory timing.
    for (int it = 0; it < 8; it++) begin
      do_free();
      do_cfg($urandom_range(1, DEPTH), $urandom_range(1, LANES), $urandom_range(1, MAX_LAYERS), 1'b1);
      do_load(2);
      do_pass(1'b0, 1'b0);
      if (it % 2 == 1) do_pass(1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
